// File: rtl/i2c_target_receiver.sv
// Write-only I2C target decoding 3-byte codec frames {DEV_ADDR,W}, {reg[6:0],d8}, data[7:0].
// The bus is oversampled on i_clk; each complete word is presented with a one-cycle o_valid.
module i2c_target_receiver #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_sdat,
    output logic       o_oen,
    output logic       o_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_BYTE,
        S_BYTE_ACK,
        S_IGNORE
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_prev_reg, sda_prev_reg;
    logic [3:0] bitcnt_reg, bitcnt_next;
    logic [1:0] bytecnt_reg, bytecnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [6:0] shadow_addr_reg, shadow_addr_next;
    logic       shadow_d8_reg, shadow_d8_next;
    logic       oen_reg, oen_next;
    logic       valid_reg, valid_next;
    logic       err_reg, err_next;
    logic [6:0] reg_addr_reg, reg_addr_next;
    logic [8:0] reg_data_reg, reg_data_next;

    logic       scl_cur, sda_cur;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_evt, stop_evt;
    logic       word_open;
    logic [7:0] shifted;

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], i_sclk};
            sda_sync_reg <= {sda_sync_reg[0], i_sdat};
            scl_prev_reg <= scl_sync_reg[1];
            sda_prev_reg <= sda_sync_reg[1];
        end
    end

    assign scl_cur  = scl_sync_reg[1];
    assign sda_cur  = sda_sync_reg[1];
    assign scl_rise = !scl_prev_reg && scl_cur;
    assign scl_fall = scl_prev_reg && !scl_cur;
    assign sda_rise = !sda_prev_reg && sda_cur;
    assign sda_fall = sda_prev_reg && !sda_cur;

    // Our own ACK drive must never be mistaken for START/STOP
    assign start_evt = scl_cur && sda_fall && !oen_reg;
    assign stop_evt  = scl_cur && sda_rise && !oen_reg;

    assign word_open = (state_reg == S_BYTE || state_reg == S_BYTE_ACK) && (bytecnt_reg != 2'd3);
    assign shifted   = {shift_reg[6:0], sda_cur};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg       <= S_IDLE;
            bitcnt_reg      <= 4'd0;
            bytecnt_reg     <= 2'd0;
            shift_reg       <= 8'd0;
            shadow_addr_reg <= 7'd0;
            shadow_d8_reg   <= 1'b0;
            oen_reg         <= 1'b0;
            valid_reg       <= 1'b0;
            err_reg         <= 1'b0;
            reg_addr_reg    <= 7'd0;
            reg_data_reg    <= 9'd0;
        end else begin
            state_reg       <= state_next;
            bitcnt_reg      <= bitcnt_next;
            bytecnt_reg     <= bytecnt_next;
            shift_reg       <= shift_next;
            shadow_addr_reg <= shadow_addr_next;
            shadow_d8_reg   <= shadow_d8_next;
            oen_reg         <= oen_next;
            valid_reg       <= valid_next;
            err_reg         <= err_next;
            reg_addr_reg    <= reg_addr_next;
            reg_data_reg    <= reg_data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bitcnt_next      = bitcnt_reg;
        bytecnt_next     = bytecnt_reg;
        shift_next       = shift_reg;
        shadow_addr_next = shadow_addr_reg;
        shadow_d8_next   = shadow_d8_reg;
        oen_next         = oen_reg;
        valid_next       = 1'b0;
        err_next         = 1'b0;
        reg_addr_next    = reg_addr_reg;
        reg_data_next    = reg_data_reg;

        if (start_evt) begin
            state_next   = S_ADDR;
            bitcnt_next  = 4'd0;
            bytecnt_next = 2'd0;
            oen_next     = 1'b0;
            err_next     = word_open;
        end else if (stop_evt) begin
            state_next = S_IDLE;
            oen_next   = 1'b0;
            err_next   = (state_reg == S_ADDR) || (state_reg == S_ADDR_ACK) || word_open;
        end else begin
            case (state_reg)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_next  = shifted;
                        bitcnt_next = bitcnt_reg + 4'd1;
                    end else if (scl_fall && bitcnt_reg == 4'd8) begin
                        bitcnt_next = 4'd0;
                        if (shift_reg[7:1] == DEV_ADDR && !shift_reg[0]) begin
                            oen_next   = 1'b1;
                            state_next = S_ADDR_ACK;
                        end else begin
                            state_next = S_IGNORE;
                            err_next   = (shift_reg[7:1] == DEV_ADDR);
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        oen_next     = 1'b0;
                        bitcnt_next  = 4'd0;
                        bytecnt_next = 2'd1;
                        state_next   = S_BYTE;
                    end
                end
                S_BYTE: begin
                    if (scl_rise) begin
                        shift_next  = shifted;
                        bitcnt_next = bitcnt_reg + 4'd1;
                        if (bitcnt_reg == 4'd7) begin
                            if (bytecnt_reg == 2'd1) begin
                                shadow_addr_next = shifted[7:1];
                                shadow_d8_next   = shifted[0];
                            end else if (bytecnt_reg == 2'd2) begin
                                reg_addr_next = shadow_addr_reg;
                                reg_data_next = {shadow_d8_reg, shifted};
                                valid_next    = 1'b1;
                            end
                        end
                    end else if (scl_fall && bitcnt_reg == 4'd8) begin
                        bitcnt_next = 4'd0;
                        if (bytecnt_reg != 2'd3) begin
                            oen_next   = 1'b1;
                            state_next = S_BYTE_ACK;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_IGNORE;
                        end
                    end
                end
                S_BYTE_ACK: begin
                    if (scl_fall) begin
                        oen_next     = 1'b0;
                        bitcnt_next  = 4'd0;
                        bytecnt_next = bytecnt_reg + 2'd1;
                        state_next   = S_BYTE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sdat     = 1'b0;
    assign o_oen      = oen_reg;
    assign o_valid    = valid_reg;
    assign o_err      = err_reg;
    assign o_reg_addr = reg_addr_reg;
    assign o_reg_data = reg_data_reg;
    assign o_busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Bench for i2c_target_receiver: a bit-banged I2C master plus a frame-level model that
// predicts ACKs, delivered words and error pulses from the byte sequence sent.
module tb_i2c_target_receiver;

    localparam logic [6:0] DEV = 7'h1A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sdat_out, oen, valid, busy, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;

    assign sda_bus = sda_m & ~oen;

    i2c_target_receiver #(.DEV_ADDR(DEV)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (scl),
        .i_sdat     (sda_bus),
        .o_sdat     (sdat_out),
        .o_oen      (oen),
        .o_valid    (valid),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] frame_t [5];
    typedef struct packed {
        logic [6:0] a;
        logic [8:0] d;
    } word_t;

    word_t      exp_q[$];
    word_t      cw;
    logic [6:0] last_a = 7'd0;
    logic [8:0] last_d = 9'd0;
    int tests = 0, fails = 0;
    int err_seen = 0, exp_err = 0, pending_err = 0, valid_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's expected word stream
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("sdat_const", {31'd0, sdat_out}, 32'd0);
            if (err) err_seen++;
            if (valid) begin
                valid_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL valid_strobe: got word %0h/%0h, required no strobe (t=%0t)",
                             reg_addr, reg_data, $time);
                end else begin
                    cw = exp_q.pop_front();
                    last_a = cw.a;
                    last_d = cw.d;
                end
            end
            chk("reg_addr", {25'd0, reg_addr}, {25'd0, last_a});
            chk("reg_data", {23'd0, reg_data}, {23'd0, last_d});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        exp_err += pending_err;
        pending_err = 0;
        sda_m = 1'b1; tick(4);
        scl = 1'b1;   tick(8);
        sda_m = 1'b0; tick(8);
        scl = 1'b0;   tick(4);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(4);
        scl = 1'b1;   tick(8);
        sda_m = 1'b1; tick(16);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("err_count", err_seen, exp_err);
        chk("words_left", exp_q.size(), 32'd0);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(4);
        scl = 1'b1; tick(4);
        chk("oen_data_bit", {31'd0, oen}, 32'd0);
        tick(4);
        scl = 1'b0; tick(4);
    endtask

    task automatic ack_bit(output logic ack);
        sda_m = 1'b1; tick(4);
        scl = 1'b1;   tick(4);
        ack = oen;    tick(4);
        scl = 1'b0;   tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(ack);
    endtask

    // Frame-level model: ACKs, delivered word and error pulses follow from the bytes sent
    task automatic run_frame(input frame_t b, input int nbytes, input int cut, input bit do_stop);
        logic ack;
        bit   addressed;
        addressed = (nbytes >= 1) && (b[0] == 8'h34);
        $display("[TB] frame %02h %02h %02h %02h nbytes=%0d cut=%0d stop=%0d",
                 b[0], b[1], b[2], b[3], nbytes, cut, do_stop);
        if (addressed && nbytes >= 3) exp_q.push_back({b[1][7:1], b[1][0], b[2]});
        if (nbytes >= 1 && b[0][7:1] == DEV && b[0][0]) exp_err++;
        if (addressed && nbytes >= 4) exp_err++;
        bus_start();
        for (int i = 0; i < nbytes; i++) begin
            send_byte(b[i], ack);
            chk($sformatf("ack_byte%0d", i), {31'd0, ack}, {31'd0, (addressed && i < 3)});
        end
        for (int j = 0; j < cut; j++) send_bit(1'($urandom_range(0, 1)));
        if (do_stop) begin
            if (nbytes == 0 || (addressed && nbytes < 3)) exp_err++;
            bus_stop();
        end else begin
            pending_err = (addressed && (nbytes == 1 || nbytes == 2)) ? 1 : 0;
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     f;
        logic       ack;
        logic [7:0] partial;
        int e0, v0, r, n, cut;
        bit stp;

        tick(3);
        rst_n = 1'b1;
        chk("rst_oen",   {31'd0, oen},   32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_addr",  {25'd0, reg_addr}, 32'd0);
        chk("rst_data",  {23'd0, reg_data}, 32'd0);
        chk_en = 1'b1;
        tick(4);

        // Basic frame
        f = '{8'h34, 8'h08, 8'h15, 8'h00, 8'h00};
        run_frame(f, 3, 0, 1'b1);
        chk("basic_addr", {25'd0, reg_addr}, 32'h04);
        chk("basic_data", {23'd0, reg_data}, 32'h015);
        chk("basic_valid_cnt", valid_cnt, 32'd1);
        chk("basic_no_err", err_seen, 32'd0);

        // Reset in the middle of a data byte with SCL low
        bus_start();
        send_byte(8'h34, ack);
        chk("rst_mid_addr_ack", {31'd0, ack}, 32'd1);
        partial = 8'h12;
        for (int i = 7; i >= 5; i--) send_bit(partial[i]);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        last_a = 7'd0; last_d = 9'd0;
        err_seen = 0; exp_err = 0; pending_err = 0;
        tick(1);
        rst_n = 1'b1;
        chk("midrst_oen",   {31'd0, oen},   32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        chk("midrst_addr",  {25'd0, reg_addr}, 32'd0);
        chk("midrst_data",  {23'd0, reg_data}, 32'd0);
        for (int i = 4; i >= 0; i--) send_bit(partial[i]);
        ack_bit(ack);
        chk("midrst_no_ack1", {31'd0, ack}, 32'd0);
        send_byte(8'h01, ack);
        chk("midrst_no_ack2", {31'd0, ack}, 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        f = '{8'h34, 8'h12, 8'h01, 8'h00, 8'h00};
        run_frame(f, 3, 0, 1'b1);
        chk("midrst_word_addr", {25'd0, reg_addr}, 32'h09);
        chk("midrst_word_data", {23'd0, reg_data}, 32'h001);

        // Ten back-to-back frames, registers 0..9
        v0 = valid_cnt;
        for (int k = 0; k < 10; k++) begin
            f[0] = 8'h34;
            f[1] = {7'(k), 1'($urandom_range(0, 1))};
            f[2] = 8'($urandom);
            if (k == 9) begin
                f[1] = 8'h12;
                f[2] = 8'h01;
            end
            run_frame(f, 3, 0, 1'b1);
        end
        chk("ten_valid_cnt", valid_cnt - v0, 32'd10);
        chk("ten_last_addr", {25'd0, reg_addr}, 32'h09);
        chk("ten_last_data", {23'd0, reg_data}, 32'h001);

        // Foreign address, then matching address with read bit
        e0 = err_seen;
        f = '{8'h36, 8'h08, 8'h15, 8'h00, 8'h00};
        run_frame(f, 3, 0, 1'b1);
        chk("foreign_no_err", err_seen - e0, 32'd0);
        f = '{8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(f, 1, 0, 1'b1);
        chk("read_err_once", err_seen - e0, 32'd1);

        // STOP after two bytes: abort, outputs unchanged
        e0 = err_seen;
        f = '{8'h34, 8'h08, 8'h00, 8'h00, 8'h00};
        run_frame(f, 2, 0, 1'b1);
        chk("abort_err", err_seen - e0, 32'd1);
        chk("abort_hold_addr", {25'd0, reg_addr}, 32'h09);

        // Repeated START mid-byte, then a complete frame
        e0 = err_seen;
        f = '{8'h34, 8'h08, 8'h00, 8'h00, 8'h00};
        run_frame(f, 1, 4, 1'b0);
        f = '{8'h34, 8'h0E, 8'h00, 8'h00, 8'h00};
        run_frame(f, 3, 0, 1'b1);
        chk("restart_err", err_seen - e0, 32'd1);
        chk("restart_addr", {25'd0, reg_addr}, 32'h07);
        chk("restart_data", {23'd0, reg_data}, 32'h000);

        // Extra fourth byte is NACKed
        e0 = err_seen;
        f = '{8'h34, 8'h08, 8'h15, 8'hAA, 8'h00};
        run_frame(f, 4, 0, 1'b1);
        chk("extra_err", err_seen - e0, 32'd1);
        chk("extra_addr", {25'd0, reg_addr}, 32'h04);
        chk("extra_data", {23'd0, reg_data}, 32'h015);

        // Randomized frames: addresses, lengths, truncation and terminations
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            f[0] = (r < 7) ? 8'h34 : ((r == 7) ? 8'h35 : 8'($urandom));
            for (int i = 1; i < 5; i++) f[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            n = (r < 6) ? 3 : ((r == 6) ? 4 : $urandom_range(0, 2));
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            stp = (k == 29) || ($urandom_range(0, 3) != 0);
            run_frame(f, n, cut, stp);
        end

        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
